// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer, LSB first.
// One-entry output buffer with overrun and frame-error reporting.
module sipo_deserializer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din,
    input  logic                  din_valid,
    input  logic                  frame_start,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overrun,
    output logic                  frame_err,
    output logic [7:0]            drop_cnt
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  restart;
    logic                  complete;
    logic                  can_load;

    // Shift register contents after capturing the current bit.
    assign shifted = {din, shreg[DATA_WIDTH-1:1]};

    // A valid frame_start always begins a new word at bit 0.
    assign restart = din_valid && frame_start;

    // The word completes when the last bit lands with no resync.
    assign complete = (state == SHIFT) && din_valid &&
                      !frame_start && (cnt == LAST);

    // Buffer accepts a new word if empty or draining this cycle.
    assign can_load = !dout_valid || dout_ready;

    // Framing FSM, shift register, output buffer and event pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;

            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (restart) begin
                        shreg <= shifted;
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (din_valid) begin
                        // Stale bits of an aborted word are shifted
                        // out before the new word can complete.
                        shreg <= shifted;
                        if (frame_start) begin
                            frame_err <= 1'b1;
                            cnt       <= CW'(1);
                        end else if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            if (complete) begin
                if (can_load) begin
                    dout       <= shifted;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                    if (drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_sipo_deserializer;

    localparam int W = 16;

    logic         clk;
    logic         resetn;
    logic         din;
    logic         din_valid;
    logic         frame_start;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         overrun;
    logic         frame_err;
    logic [7:0]   drop_cnt;

    int compared;
    int mismatched;

    sipo_deserializer #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        din_valid   = 1'b0;
        frame_start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        din         = b;
        din_valid   = 1'b1;
        frame_start = fs;
        @(posedge clk);
        #1;
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Send bits lo..hi of w, optionally with a gap cycle before each.
    task automatic send_range(input logic [W-1:0] w, input int lo,
                              input int hi, input bit gap,
                              input bit fs_first);
        for (int i = lo; i <= hi; i++) begin
            if (gap) idle();
            send_bit(w[i], fs_first && (i == lo));
        end
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        resetn      = 1'b0;
        din         = 1'b0;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        dout_ready  = 1'b1;

        // Reset state
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_dv", 32'(dout_valid), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Bits without frame_start in IDLE are ignored
        send_range(16'hFFFF, 0, 15, 0, 0);
        chk("idle_ignore_dv", 32'(dout_valid), 32'h0);

        // Basic back-to-back word
        send_range(16'hA5C3, 0, 14, 0, 1);
        chk("basic_dv_early", 32'(dout_valid), 32'h0);
        send_range(16'hA5C3, 15, 15, 0, 0);
        chk("basic_dv", 32'(dout_valid), 32'h1);
        chk("basic_dout", 32'(dout), 32'hA5C3);
        idle();
        chk("basic_dv_fall", 32'(dout_valid), 32'h0);

        // Gapped input
        send_range(16'hA5C3, 0, 14, 1, 1);
        chk("gap_dv_early", 32'(dout_valid), 32'h0);
        send_range(16'hA5C3, 15, 15, 1, 0);
        chk("gap_dv", 32'(dout_valid), 32'h1);
        chk("gap_dout", 32'(dout), 32'hA5C3);
        idle();
        chk("gap_dv_fall", 32'(dout_valid), 32'h0);

        // Backpressure and overrun
        dout_ready = 1'b0;
        send_range(16'h1234, 0, 15, 0, 1);
        chk("bp_dv", 32'(dout_valid), 32'h1);
        chk("bp_dout1", 32'(dout), 32'h1234);
        send_range(16'hBEEF, 0, 14, 0, 1);
        chk("bp_ovr_early", 32'(overrun), 32'h0);
        send_range(16'hBEEF, 15, 15, 0, 0);
        chk("bp_ovr", 32'(overrun), 32'h1);
        chk("bp_dout_hold", 32'(dout), 32'h1234);
        chk("bp_drop", 32'(drop_cnt), 32'h1);
        idle();
        chk("bp_ovr_pulse", 32'(overrun), 32'h0);
        chk("bp_dv_hold", 32'(dout_valid), 32'h1);
        dout_ready = 1'b1;
        idle();
        chk("bp_accept_dv", 32'(dout_valid), 32'h0);

        // Simultaneous drain and load
        dout_ready = 1'b0;
        send_range(16'h00FF, 0, 15, 0, 1);
        chk("sim_dout1", 32'(dout), 32'h00FF);
        send_range(16'hFF00, 0, 14, 0, 1);
        dout_ready = 1'b1;
        send_range(16'hFF00, 15, 15, 0, 0);
        chk("sim_dout2", 32'(dout), 32'hFF00);
        chk("sim_dv", 32'(dout_valid), 32'h1);
        chk("sim_ovr", 32'(overrun), 32'h0);
        chk("sim_drop", 32'(drop_cnt), 32'h1);
        idle();
        chk("sim_dv_fall", 32'(dout_valid), 32'h0);

        // Resync after 5 bits
        send_range(16'h001F, 0, 4, 0, 1);
        chk("rs_ferr_early", 32'(frame_err), 32'h0);
        send_range(16'h5A5A, 0, 0, 0, 1);
        chk("rs_ferr", 32'(frame_err), 32'h1);
        send_range(16'h5A5A, 1, 1, 0, 0);
        chk("rs_ferr_pulse", 32'(frame_err), 32'h0);
        send_range(16'h5A5A, 2, 14, 0, 0);
        chk("rs_dv_early", 32'(dout_valid), 32'h0);
        send_range(16'h5A5A, 15, 15, 0, 0);
        chk("rs_dout", 32'(dout), 32'h5A5A);
        chk("rs_dv", 32'(dout_valid), 32'h1);
        idle();

        // Reset mid-word with a pending word and nonzero drop count
        dout_ready = 1'b0;
        send_range(16'h1111, 0, 15, 0, 1);
        chk("mr_pending", 32'(dout_valid), 32'h1);
        send_range(16'h3C3C, 0, 8, 0, 1);
        resetn = 1'b0;
        #1;
        chk("mr_dout", 32'(dout), 32'h0);
        chk("mr_dv", 32'(dout_valid), 32'h0);
        chk("mr_drop", 32'(drop_cnt), 32'h0);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        send_range(16'h3C3C, 9, 15, 0, 0);
        send_range(16'hFFFF, 0, 15, 0, 0);
        chk("mr_ignore_dv", 32'(dout_valid), 32'h0);
        chk("mr_ignore_dout", 32'(dout), 32'h0);

        // Drop counter saturation
        send_range(16'h0001, 0, 15, 0, 1);
        chk("sat_load", 32'(dout), 32'h0001);
        for (int i = 1; i <= 300; i++) begin
            send_range(16'hCAFE, 0, 15, 0, 1);
            if (i == 254) chk("sat_254", 32'(drop_cnt), 32'd254);
            if (i == 255) chk("sat_255", 32'(drop_cnt), 32'd255);
        end
        chk("sat_final", 32'(drop_cnt), 32'd255);
        chk("sat_ovr", 32'(overrun), 32'h1);
        chk("sat_dout", 32'(dout), 32'h0001);
        dout_ready = 1'b1;
        idle();
        chk("sat_accept", 32'(dout_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, word width in bits; SHALL be >= 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 Port: din  input  1  serial data bit, LSB of each word first.
REQ-005 Port: din_valid  input  1  din carries a valid bit this cycle.
REQ-006 Port: frame_start  input  1  qualified by din_valid; marks the current bit as bit 0 of a new word.
REQ-007 Port: dout  output  DATA_WIDTH  assembled parallel word.
REQ-008 Port: dout_valid  output  1  dout holds an undelivered word.
REQ-009 Port: dout_ready  input  1  consumer accepts dout when dout_valid and dout_ready are both high.
REQ-010 Port: overrun  output  1  one-cycle pulse: a completed word was dropped.
REQ-011 Port: frame_err  output  1  one-cycle pulse: a partial word was aborted by frame_start.
REQ-012 Port: drop_cnt  output  8  count of dropped words, saturating at 255.

Function
REQ-013 State machine SHALL have two states: IDLE (no word in progress) and SHIFT (word in progress).
REQ-014 Bit counter cnt SHALL be $clog2(DATA_WIDTH) bits wide and SHALL count the bits captured in the current word.
REQ-015 Shift register SHALL capture a bit only when din_valid=1, as shreg <= {din, shreg[DATA_WIDTH-1:1]}, so the first bit ends up at dout[0].
REQ-016 IDLE with din_valid=1 and frame_start=1: SHALL capture bit 0, set cnt=1, and go to SHIFT.
REQ-017 IDLE with din_valid=1 and frame_start=0: the bit SHALL be ignored; no state change.
REQ-018 SHIFT with din_valid=0: SHALL hold all state (no timeout).
REQ-019 SHIFT with din_valid=1 and frame_start=0: SHALL capture the bit and increment cnt.
REQ-020 Completion: the bit captured with cnt=DATA_WIDTH-1 SHALL complete the word and return the FSM to IDLE.
REQ-021 SHIFT with din_valid=1 and frame_start=1: SHALL pulse frame_err for 1 cycle, discard the partial word, capture this bit as bit 0, set cnt=1, and stay in SHIFT.
REQ-022 Output buffer is one entry: dout/dout_valid SHALL be registered; dout_valid SHALL rise on the edge that captures the completing bit, giving one cycle of latency from the last bit.
REQ-023 A completed word SHALL load the buffer if dout_valid=0, or if dout_valid=1 and dout_ready=1 in the same cycle (simultaneous drain and load; dout_valid stays 1).
REQ-024 Handshake: with dout_valid=1 and dout_ready=0, dout SHALL remain stable.
REQ-025 Handshake: dout_valid SHALL fall after acceptance unless a new word loads in the same cycle.
REQ-026 A completed word arriving while dout_valid=1 and dout_ready=0 SHALL be dropped: buffer unchanged, overrun pulses for 1 cycle, drop_cnt increments unless it is already 255.
REQ-027 dout_ready SHALL be ignored while dout_valid=0.
REQ-028 overrun and frame_err SHALL be registered pulses, high for exactly one cycle per event.

Reset
REQ-029 resetn=0 SHALL asynchronously force: FSM=IDLE, cnt=0, shreg=0, dout=0, dout_valid=0, overrun=0, frame_err=0, drop_cnt=0.
REQ-030 Reset asserted mid-word SHALL discard the partial word; after release, the FSM SHALL wait for a new frame_start.
REQ-031 After resetn deasserts, the first capture SHALL occur on the first rising edge with din_valid=1.

Verification
REQ-032 Basic word: resetn released, 16 bits of 0xA5C3 sent LSB-first back-to-back with frame_start on the first bit, dout_ready=1 -> dout=0xA5C3 with dout_valid high for 1 cycle, one cycle after the last bit.
REQ-033 Gapped input: din_valid toggled 1/0 across the same word -> identical result; dout_valid only after the 16th valid bit.
REQ-034 Backpressure: dout_ready=0 while words 0x1234 and 0xBEEF both complete -> dout holds 0x1234, overrun pulses once, drop_cnt=1; then dout_ready=1 -> 0x1234 accepted, dout_valid=0.
REQ-035 Simultaneous drain and load: word 0x00FF pending, 0xFF00 completes in the cycle dout_ready=1 -> dout=0xFF00, dout_valid stays 1, no overrun.
REQ-036 Resync: frame_start reasserted after 5 bits, followed by 16 bits of 0x5A5A -> frame_err pulses once, dout=0x5A5A.
REQ-037 Reset mid-word: resetn pulsed low after 9 bits -> all outputs 0 immediately; bits sent without frame_start afterwards are ignored; drop_cnt saturates at 255 after 300 forced drops.
